// File: rtl/mux_nx1_rr.sv
// N-input, W-bit registered multiplexer with valid/ready handshake, fixed or round-robin select.
// Optional: define MUXRR_BEAT_CNT_EN to add the 16-bit accepted-word counter port beat_cnt.
module mux_nx1_rr #(
  parameter int N = 4,
  parameter int W = 8,
  localparam int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic           mode,
  input  logic [SW-1:0]  s,
  output logic [W-1:0]   y,
  output logic           y_valid,
  input  logic           y_ready,
  output logic [SW-1:0]  y_ch
`ifdef MUXRR_BEAT_CNT_EN
  ,
  output logic [15:0]    beat_cnt
`endif
);

  logic [W-1:0]  ch_data [N];
  logic [SW-1:0] ptr;
  logic [SW-1:0] g;
  logic          grant_valid;
  logic          load;
  logic [SW:0]   rr_sum;

  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      ch_data[i] = in_data[i*W +: W];
    end
  end

  // Round-robin scans ptr, ptr+1, ... modulo N; the first valid channel wins.
  always_comb begin
    grant_valid = 1'b0;
    g           = '0;
    rr_sum      = '0;
    if (mode) begin
      for (int unsigned k = 0; k < N; k++) begin
        rr_sum = {1'b0, ptr} + (SW+1)'(k);
        if (rr_sum >= (SW+1)'(N)) begin
          rr_sum = rr_sum - (SW+1)'(N);
        end
        if (!grant_valid && in_valid[rr_sum[SW-1:0]]) begin
          grant_valid = 1'b1;
          g           = rr_sum[SW-1:0];
        end
      end
    end else if ({1'b0, s} < (SW+1)'(N)) begin
      grant_valid = in_valid[s];
      g           = s;
    end
  end

  assign load = (!y_valid || y_ready) && grant_valid;

  always_comb begin
    in_ready = '0;
    if (load) begin
      in_ready[g] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y       <= '0;
      y_valid <= 1'b0;
      y_ch    <= '0;
    end else if (load) begin
      y       <= ch_data[g];
      y_ch    <= g;
      y_valid <= 1'b1;
    end else if (y_ready) begin
      y_valid <= 1'b0;
    end
  end

  // The pointer only moves on round-robin loads; it survives mode switches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (load && mode) begin
      ptr <= (g == SW'(N-1)) ? '0 : g + 1'b1;
    end
  end

`ifdef MUXRR_BEAT_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
    end else if (load) begin
      beat_cnt <= beat_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mux_nx1_rr.sv
// Directed, table-driven bench for mux_nx1_rr (N=4, W=8), plus reset and stall sequences.
module tb_mux_nx1_rr;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic           mode;
  logic [SW-1:0]  s;
  logic [W-1:0]   y;
  logic           y_valid;
  logic           y_ready;
  logic [SW-1:0]  y_ch;
`ifdef MUXRR_BEAT_CNT_EN
  logic [15:0]    beat_cnt;
`endif

  always #5 clk = ~clk;

  mux_nx1_rr #(.N(N), .W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mode     (mode),
    .s        (s),
    .y        (y),
    .y_valid  (y_valid),
    .y_ready  (y_ready),
    .y_ch     (y_ch)
`ifdef MUXRR_BEAT_CNT_EN
    ,
    .beat_cnt (beat_cnt)
`endif
  );

  typedef struct {
    logic           mode;
    logic [SW-1:0]  s;
    logic [N-1:0]   iv;
    logic [N*W-1:0] data;
    logic           yr;
    logic [N-1:0]   exp_ir;
    logic           exp_yv;
    logic [W-1:0]   exp_y;
    logic [SW-1:0]  exp_ch;
  } vec_t;

  vec_t vecs [13];
  int   tests  = 0;
  int   failed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    // RR, all valid, starting from ptr=0: channels 0,1,2,3,0,1
    vecs[0]  = '{1'b1, 2'd0, 4'b1111, 32'h13121110, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
    vecs[1]  = '{1'b1, 2'd0, 4'b1111, 32'h13121110, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
    vecs[2]  = '{1'b1, 2'd0, 4'b1111, 32'h13121110, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2};
    vecs[3]  = '{1'b1, 2'd0, 4'b1111, 32'h13121110, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3};
    vecs[4]  = '{1'b1, 2'd0, 4'b1111, 32'h13121110, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
    vecs[5]  = '{1'b1, 2'd0, 4'b1111, 32'h13121110, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
    // ptr=2, only ch0 valid: wraps to 0, ptr becomes 1
    vecs[6]  = '{1'b1, 2'd0, 4'b0001, 32'h13121110, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
    // sparse 1001: ptr=1 -> grant 3, then ptr=0 -> grant 0
    vecs[7]  = '{1'b1, 2'd0, 4'b1001, 32'h13121110, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3};
    vecs[8]  = '{1'b1, 2'd0, 4'b1001, 32'h13121110, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
    // fixed s=2
    vecs[9]  = '{1'b0, 2'd2, 4'b0100, 32'h44A52211, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2};
    // fixed s=3 with channel 3 idle: drain, then idle
    vecs[10] = '{1'b0, 2'd3, 4'b0111, 32'h55667788, 1'b1, 4'b0000, 1'b0, 8'hA5, 2'd2};
    vecs[11] = '{1'b0, 2'd3, 4'b0111, 32'h55667788, 1'b1, 4'b0000, 1'b0, 8'hA5, 2'd2};
    // back to RR: ptr retained at 1 across the fixed-mode rows
    vecs[12] = '{1'b1, 2'd0, 4'b1111, 32'hDDCCBBAA, 1'b1, 4'b0010, 1'b1, 8'hBB, 2'd1};

    rst = 1'b1; in_data = '0; in_valid = '0; mode = 1'b0; s = '0; y_ready = 1'b0;
    #1;
    chk("reset_y", 32'(y), 32'h0);
    chk("reset_yv", 32'(y_valid), 32'h0);
    chk("reset_ych", 32'(y_ch), 32'h0);
`ifdef MUXRR_BEAT_CNT_EN
    chk("reset_beat", 32'(beat_cnt), 32'h0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      mode = vecs[i].mode; s = vecs[i].s; in_valid = vecs[i].iv;
      in_data = vecs[i].data; y_ready = vecs[i].yr;
      #1;
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].exp_ir));
      @(posedge clk); #1;
      chk($sformatf("v%0d_y_valid", i), 32'(y_valid), 32'(vecs[i].exp_yv));
      chk($sformatf("v%0d_y", i), 32'(y), 32'(vecs[i].exp_y));
      chk($sformatf("v%0d_y_ch", i), 32'(y_ch), 32'(vecs[i].exp_ch));
`ifdef MUXRR_BEAT_CNT_EN
      if (i == 5) chk("beat_after_rr6", 32'(beat_cnt), 32'd6);
      if (i == 12) chk("beat_after_all", 32'(beat_cnt), 32'd11);
`endif
    end

    // Stall: y holds ch1 word BB, ptr=2; three cycles of back-pressure with changing inputs
    y_ready = 1'b0; mode = 1'b1; in_valid = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      in_data = 32'h01020304 + 32'(c) * 32'h11111111;
      #1;
      chk($sformatf("stall%0d_in_ready", c), 32'(in_ready), 32'h0);
      @(posedge clk); #1;
      chk($sformatf("stall%0d_y", c), 32'(y), 32'hBB);
      chk($sformatf("stall%0d_y_ch", c), 32'(y_ch), 32'd1);
      chk($sformatf("stall%0d_y_valid", c), 32'(y_valid), 32'd1);
    end
    y_ready = 1'b1; in_data = 32'h99887766;
    #1;
    chk("release_in_ready", 32'(in_ready), 32'b0100);
    @(posedge clk); #1;
    chk("release_y", 32'(y), 32'h88);
    chk("release_y_ch", 32'(y_ch), 32'd2);
    chk("release_y_valid", 32'(y_valid), 32'd1);

    // Async reset mid-transfer, observed before any clock edge
    y_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_y", 32'(y), 32'h0);
    chk("async_rst_yv", 32'(y_valid), 32'h0);
    chk("async_rst_ych", 32'(y_ch), 32'h0);
`ifdef MUXRR_BEAT_CNT_EN
    chk("async_rst_beat", 32'(beat_cnt), 32'h0);
`endif
    in_valid = '0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    // Pointer is back at 0 after reset
    in_valid = 4'b1111; y_ready = 1'b1; in_data = 32'h13121110;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'b0001);
    @(posedge clk); #1;
    chk("post_rst_y", 32'(y), 32'h10);
    chk("post_rst_y_ch", 32'(y_ch), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
